// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter with a one-deep holding buffer.
// Frames are start(0), DATA_BITS data bits LSB first, optional parity, and
// STOP_BITS stop bits(1). Every bit lasts exactly CLKS_PER_BIT clocks.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   tx_data  byte to transmit, captured on an accepting edge
//   tx_valid tx_data valid
//   tx_ready holding buffer empty (combinational, independent of tx_valid)
//   tx       registered serial line, idle high
//   tx_busy  frame in progress (any state but IDLE)
//   tx_done  one-cycle pulse during the final cycle of the last stop bit
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_PRE   = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic                 buf_full, buf_full_n;
  logic [DATA_BITS-1:0] buf_data, buf_data_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par, par_n;
  logic [CW-1:0]        cyc_cnt, cyc_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic                 tx_n, busy_n, done_n;
  logic                 bit_end;
  logic                 load;

  assign tx_ready = ~buf_full;
  assign bit_end  = (cyc_cnt == CYC_LAST);

  // State and datapath registers; reset forces the line high at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      buf_full <= 1'b0;
      buf_data <= '0;
      shift    <= '0;
      par      <= 1'b0;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      buf_full <= buf_full_n;
      buf_data <= buf_data_n;
      shift    <= shift_n;
      par      <= par_n;
      cyc_cnt  <= cyc_n;
      bit_cnt  <= bit_n;
      tx       <= tx_n;
      tx_busy  <= busy_n;
      tx_done  <= done_n;
    end
  end

  // Next state, counters, shift register and holding buffer.
  always_comb begin
    state_n    = state;
    cyc_n      = bit_end ? '0 : cyc_cnt + CW'(1);
    bit_n      = bit_cnt;
    shift_n    = shift;
    par_n      = par;
    load       = 1'b0;
    buf_full_n = buf_full;
    buf_data_n = buf_data;

    case (state)
      IDLE: begin
        cyc_n = '0;
        if (buf_full) begin
          state_n = START;
          load    = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_n   = bit_cnt + BW'(1);
            shift_n = shift >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          bit_n   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            bit_n = '0;
            // A pending byte starts the next frame with no idle gap.
            if (buf_full) begin
              state_n = START;
              load    = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_n = bit_cnt + BW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      shift_n    = buf_data;
      par_n      = (^buf_data) ^ (PARITY_ODD != 0);
      buf_full_n = 1'b0;
    end

    // Load and accept never share an edge: ready is low while the buffer is full.
    if (tx_valid && !buf_full) begin
      buf_full_n = 1'b1;
      buf_data_n = tx_data;
    end
  end

  // Registered outputs are decoded from the next state so tx is glitch-free.
  always_comb begin
    tx_n   = 1'b1;
    busy_n = (state_n != IDLE);
    done_n = (state == STOP) && (cyc_cnt == CYC_PRE) && (bit_cnt == STOP_LAST);
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed bytes, scoreboard queues of hand-computed
// line patterns, and a per-DUT monitor that decodes each frame like a receiver.
module tb_uart_tx;

  localparam int CPB = 16;

  typedef struct {
    logic [15:0] bits;    // bits[j] = level of j-th bit on the line
    logic [7:0]  data;
    int          start;   // expected first sample cycle of the start bit
    bit          aborted; // frame is expected to be cut short by reset
  } exp_t;

  logic       clk;
  logic       rst0, rst1;
  logic [7:0] txd0, txd1;
  logic       vld0, vld1;
  logic       rdy0, rdy1, tx0, tx1, busy0, busy1, done0, done1;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   nd0 = 0;
  int   nd1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  uart_tx dut0 (
    .clk(clk), .reset(rst0), .tx_data(txd0), .tx_valid(vld0),
    .tx_ready(rdy0), .tx(tx0), .tx_busy(busy0), .tx_done(done0)
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(rst1), .tx_data(txd1), .tx_valid(vld1),
    .tx_ready(rdy1), .tx(tx1), .tx_busy(busy1), .tx_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done0 === 1'b1) nd0 <= nd0 + 1;
    if (done1 === 1'b1) nd1 <= nd1 + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic ln_of(input int idx);
    return (idx == 0) ? tx0 : tx1;
  endfunction

  function automatic logic rst_of(input int idx);
    return (idx == 0) ? rst0 : rst1;
  endfunction

  function automatic logic busy_of(input int idx);
    return (idx == 0) ? busy0 : busy1;
  endfunction

  function automatic logic done_of(input int idx);
    return (idx == 0) ? done0 : done1;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_frame(input int idx, input logic [15:0] bits, input logic [7:0] data,
                              input int start, input bit ab);
    exp_t e;
    e.bits = bits;
    e.data = data;
    e.start = start;
    e.aborted = ab;
    if (idx == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Offer a byte; returns the cycle number of the accepting edge.
  task automatic send(input int idx, input logic [7:0] d, output int acc);
    int n;
    logic r;
    n = 0;
    @(negedge clk);
    if (idx == 0) begin txd0 = d; vld0 = 1'b1; end
    else begin txd1 = d; vld1 = 1'b1; end
    r = (idx == 0) ? rdy0 : rdy1;
    while (!r && n < 1000) begin
      @(negedge clk);
      n++;
      r = (idx == 0) ? rdy0 : rdy1;
    end
    if (!r) check("send_timeout", 32'(r), 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    if (idx == 0) vld0 = 1'b0;
    else vld1 = 1'b0;
  endtask

  // Watches one line, decodes each frame and compares it with the queue head.
  task automatic monitor(input int idx, input int nb);
    exp_t        e;
    int          fl, s, bad, done_at, qs;
    logic [7:0]  dec;
    bit          cut;
    logic        ln;
    fl = nb * CPB;
    forever begin
      @(negedge clk);
      if (rst_of(idx) !== 1'b1 || ln_of(idx) !== 1'b0) continue;
      s = cyc;
      qs = (idx == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        check($sformatf("unexpected_frame%0d", idx), 32'd1, 32'd0);
        repeat (fl) @(negedge clk);
        continue;
      end
      if (idx == 0) e = q0.pop_front();
      else e = q1.pop_front();
      check($sformatf("start_time%0d", idx), 32'(s), 32'(e.start));
      bad = 0;
      done_at = -1;
      dec = '0;
      cut = 1'b0;
      for (int t = 0; t < fl; t++) begin
        if (t > 0) @(negedge clk);
        if (rst_of(idx) !== 1'b1) begin
          cut = 1'b1;
          break;
        end
        ln = ln_of(idx);
        if (ln !== e.bits[t / CPB] || busy_of(idx) !== 1'b1) bad++;
        if (done_of(idx) === 1'b1) begin
          if (done_at < 0) done_at = t;
          else bad++;
        end
        if ((t % CPB) == CPB / 2 && t / CPB >= 1 && t / CPB <= 8) dec[t / CPB - 1] = ln;
      end
      check($sformatf("waveform%0d", idx), 32'(bad), 32'd0);
      check($sformatf("reset_cut%0d", idx), 32'(cut), 32'(e.aborted));
      if (!e.aborted) begin
        check($sformatf("done_pos%0d", idx), 32'(done_at), 32'(fl - 1));
        check($sformatf("rx_data%0d", idx), 32'(dec), 32'(e.data));
      end
    end
  endtask

  initial monitor(0, 10);
  initial monitor(1, 12);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int a, b, bad;
    rst0 = 1'b0; rst1 = 1'b0;
    txd0 = 8'hA5; txd1 = 8'h03;
    vld0 = 1'b1; vld1 = 1'b1;

    // Reset held with valid asserted: outputs stay at reset values.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_vals0", {28'd0, tx0, rdy0, busy0, done0}, 32'b1100);
      check("reset_vals1", {28'd0, tx1, rdy1, busy1, done1}, 32'b1100);
    end
    vld0 = 1'b0; vld1 = 1'b0;
    @(negedge clk);
    rst0 = 1'b1; rst1 = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || rdy0 !== 1'b1) bad++;
    end
    check("no_accept_in_reset", 32'(bad), 32'd0);

    // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1.
    send(0, 8'hA5, a);
    expect_frame(0, 16'b11_0100_1010, 8'hA5, a + 1, 1'b0);
    check("ready_after_accept", 32'(rdy0), 32'd0);
    wait_until(a + 161);
    check("idle_after_a5", {29'd0, busy0, tx0, rdy0}, 32'b011);

    // Back-to-back 0x00 then 0xFF with no idle gap.
    send(0, 8'h00, a);
    expect_frame(0, 16'b10_0000_0000, 8'h00, a + 1, 1'b0);
    send(0, 8'hFF, b);
    expect_frame(0, 16'b11_1111_1110, 8'hFF, a + 161, 1'b0);
    check("b2b_accept_edge", 32'(b), 32'(a + 2));
    bad = 0;
    while (cyc < a + 161) begin
      if (rdy0 !== 1'b0) bad++;
      @(negedge clk);
    end
    check("ready_held_low", 32'(bad), 32'd0);
    check("ready_at_second_start", 32'(rdy0), 32'd1);
    wait_until(a + 322);
    check("idle_after_b2b", {29'd0, busy0, tx0, rdy0}, 32'b011);

    // Reset during the third data bit of 0x5A (line low) with 0x11 pending.
    send(0, 8'h5A, a);
    expect_frame(0, 16'b10_1011_0100, 8'h5A, a + 1, 1'b1);
    send(0, 8'h11, b);
    wait_until(a + 1 + 3 * CPB + 5);
    check("line_low_before_reset", 32'(tx0), 32'd0);
    #2;
    rst0 = 1'b0;
    #1;
    check("async_tx_high", 32'(tx0), 32'd1);
    check("async_busy_low", 32'(busy0), 32'd0);
    check("async_buffer_clear", 32'(rdy0), 32'd1);
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || rdy0 !== 1'b1) bad++;
    end
    check("idle_after_reset", 32'(bad), 32'd0);

    // Loopback decode of 0x3C.
    send(0, 8'h3C, a);
    expect_frame(0, 16'b10_0111_1000, 8'h3C, a + 1, 1'b0);
    wait_until(a + 165);

    // Odd parity, two stop bits: 0x03 -> parity 1, 0x01 -> parity 0.
    send(1, 8'h03, a);
    expect_frame(1, 16'b1110_0000_0110, 8'h03, a + 1, 1'b0);
    wait_until(a + 193);
    check("idle_after_parity_frame", {30'd0, busy1, tx1}, 32'b01);
    send(1, 8'h01, a);
    expect_frame(1, 16'b1100_0000_0010, 8'h01, a + 1, 1'b0);
    wait_until(a + 200);

    check("done_count0", 32'(nd0), 32'd4);
    check("done_count1", 32'(nd1), 32'd2);
    check("queue_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
